counter_monitor: RTL and testbench
==================================

// Module: counter_monitor
// PURPOSE
//  Observer (receive side) for the 4-bit shortcut up-counter interface (rst_n, shortcut, out).
//  Predicts the counter's next value each cycle, compares it against the observed value,
//  and reports mismatches, wrap events and error statistics.
//  Sits beside the counter in BMC/simulation harnesses as a checker. Drives no DUT inputs.
// PARAMETERS
//  WIDTH      4   counter width; the shortcut target is all-ones and wrap is modulo 2**WIDTH
//  ERR_CNT_W  8   width of err_count and wrap_count (both saturate)
// PORTS
//  clk           in   1          clock; the counter samples on the same posedge
//  rst           in   1          synchronous, active-high monitor reset
//  dut_rst_n     in   1          observed counter reset (active-low, synchronous)
//  dut_shortcut  in   1          observed shortcut request
//  dut_out       in   WIDTH      observed counter output
//  exp_out       out  WIDTH      predicted value for the current cycle (valid in TRACK/ERROR)
//  exp_valid     out  1          exp_out is meaningful
//  mismatch      out  1          1-cycle pulse: dut_out != exp_out while exp_valid
//  err_sticky    out  1          set on first mismatch; cleared only by rst
//  err_count     out  ERR_CNT_W  number of mismatches, saturates at all-ones
//  wrap_count    out  ERR_CNT_W  count-path wraps (all-ones -> 0), saturates
//  state         out  2          00 SYNC, 01 TRACK, 10 ERROR
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=SYNC, exp_out=0, exp_valid=0, mismatch=0, err_sticky=0,
//    err_count=0, wrap_count=0. rst overrides all other activity, including mid-TRACK.
//  Next-value function nxt(v): dut_rst_n==0 -> 0; else dut_shortcut==1 -> {WIDTH{1}};
//    else v+1 mod 2**WIDTH. Reset beats shortcut when both are active in the same cycle.
//  SYNC: at the first posedge after rst, load exp_out <= nxt(dut_out) and set exp_valid=1.
//    No comparison is made. Go to TRACK.
//  TRACK: each posedge compares dut_out with exp_out.
//    equal -> exp_out <= nxt(dut_out); stay in TRACK.
//    differ -> mismatch=1 for one cycle; err_sticky=1; err_count+=1 (saturating);
//      exp_out <= nxt(dut_out), i.e. resync to the observed value; go to ERROR.
//  ERROR: same compare/resync as TRACK. Further mismatches pulse and count.
//    Stays in ERROR until rst; there is no return to TRACK.
//  Timing: mismatch is registered, so it asserts the cycle after the bad dut_out is sampled.
//  wrap_count increments when exp_out is loaded via the +1 path from dut_out=={WIDTH{1}}.
//    It does not increment for the shortcut or reset paths.
//    It increments only when the compare matched (TRACK/ERROR) or in SYNC.
//  Saturation: err_count and wrap_count hold at 2**ERR_CNT_W-1. mismatch still pulses.
//  Purely combinational on the inputs apart from the registered outputs listed above.
//    No latches. All outputs are driven from flops.
// TESTING
//  1 rst, then dut_rst_n=0 for 2 cycles, then count 0..5 -> exp_out tracks, mismatch never 1,
//    state=TRACK.
//  2 Count to 14, then dut_shortcut=1 with out->15, next count 0 -> no mismatch; wrap_count=1.
//  3 Count 3 -> 4, then force dut_out=9 -> mismatch pulses 1 cycle; err_sticky=1;
//    err_count=1; state=ERROR; next exp_out=10.
//  4 dut_rst_n=0 and dut_shortcut=1 together at out=7 -> expected 0; observed 15 flags a mismatch.
//  5 Inject 300 mismatches (ERR_CNT_W=8) -> err_count holds at 255; mismatch pulses every time.
//  6 rst mid-ERROR -> next cycle state=SYNC, err_sticky=0, counts=0; following cycle TRACK.

Source files
------------

// File: rtl/counter_monitor.sv
// Receive-side checker for a WIDTH-bit up-counter with synchronous active-low reset and
// an all-ones shortcut: predicts each observed value, flags and counts mismatches and wraps.
module counter_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dut_rst_n,
    input  logic                 dut_shortcut,
    input  logic [WIDTH-1:0]     dut_out,
    output logic [WIDTH-1:0]     exp_out,
    output logic                 exp_valid,
    output logic                 mismatch,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ERR_CNT_W-1:0] wrap_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_exp_out,    w_exp_out_next;
    logic                 r_exp_valid,  w_exp_valid_next;
    logic                 r_mismatch,   w_mismatch_next;
    logic                 r_err_sticky, w_err_sticky_next;
    logic [ERR_CNT_W-1:0] r_err_count,  w_err_count_next;
    logic [ERR_CNT_W-1:0] r_wrap_count, w_wrap_count_next;

    logic [WIDTH-1:0]     w_nxt;
    logic                 w_wrap_path;
    logic                 w_differ;

    // Counter reset has priority over the shortcut; otherwise count modulo 2**WIDTH.
    assign w_nxt       = !dut_rst_n   ? '0 :
                         dut_shortcut ? '1 : WIDTH'(dut_out + WIDTH'(1));
    assign w_wrap_path = dut_rst_n && !dut_shortcut && (dut_out == '1);
    assign w_differ    = (dut_out != r_exp_out);

    always_comb begin
        w_state_next      = r_state;
        w_exp_out_next    = r_exp_out;
        w_exp_valid_next  = r_exp_valid;
        w_mismatch_next   = 1'b0;
        w_err_sticky_next = r_err_sticky;
        w_err_count_next  = r_err_count;
        w_wrap_count_next = r_wrap_count;
        case (r_state)
            ST_SYNC: begin
                w_exp_out_next   = w_nxt;
                w_exp_valid_next = 1'b1;
                w_state_next     = ST_TRACK;
                if (w_wrap_path && (r_wrap_count != '1))
                    w_wrap_count_next = r_wrap_count + ERR_CNT_W'(1);
            end
            ST_TRACK, ST_ERROR: begin
                // Always resync to the observed value so one glitch is reported once.
                w_exp_out_next = w_nxt;
                if (w_differ) begin
                    w_mismatch_next   = 1'b1;
                    w_err_sticky_next = 1'b1;
                    w_state_next      = ST_ERROR;
                    if (r_err_count != '1)
                        w_err_count_next = r_err_count + ERR_CNT_W'(1);
                end else if (w_wrap_path && (r_wrap_count != '1)) begin
                    w_wrap_count_next = r_wrap_count + ERR_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SYNC;
            r_exp_out    <= '0;
            r_exp_valid  <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_exp_out    <= w_exp_out_next;
            r_exp_valid  <= w_exp_valid_next;
            r_mismatch   <= w_mismatch_next;
            r_err_sticky <= w_err_sticky_next;
            r_err_count  <= w_err_count_next;
            r_wrap_count <= w_wrap_count_next;
        end
    end

    assign state      = r_state;
    assign exp_out    = r_exp_out;
    assign exp_valid  = r_exp_valid;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: a stimulus process drives a modelled counter (with
// injected faults) and queues predicted monitor outputs; a monitor process pops and compares.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dut_rst_n = 1'b1;
    logic       dut_shortcut = 1'b0;
    logic [3:0] dut_out = 4'd0;
    logic [3:0] exp_out;
    logic       exp_valid;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [1:0] state;

    counter_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .dut_rst_n    (dut_rst_n),
        .dut_shortcut (dut_shortcut),
        .dut_out      (dut_out),
        .exp_out      (exp_out),
        .exp_valid    (exp_valid),
        .mismatch     (mismatch),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .wrap_count   (wrap_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state;
        int exp_out;
        int exp_valid;
        int mismatch;
        int err_sticky;
        int err_count;
        int wrap_count;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 0;

    // Reference model of what the monitor should conclude.
    bit m_synced, m_errflag, m_sticky, m_valid;
    int m_pred, m_errc, m_wrapc;
    int cnt;

    function automatic int nxt(bit rn, bit sc, int v);
        if (!rn) return 0;
        if (sc) return 15;
        return (v + 1) % 16;
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(string name, int act, int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(bit r, bit rn, bit sc, int out);
        exp_t e;
        @(negedge clk);
        rst          = r;
        dut_rst_n    = rn;
        dut_shortcut = sc;
        dut_out      = out[3:0];
        e.mismatch   = 0;
        if (r) begin
            m_synced = 0; m_errflag = 0; m_sticky = 0; m_valid = 0;
            m_pred = 0; m_errc = 0; m_wrapc = 0;
        end else if (!m_synced) begin
            if (rn && !sc && out == 15) m_wrapc = sat(m_wrapc + 1);
            m_pred = nxt(rn, sc, out);
            m_synced = 1;
            m_valid = 1;
        end else begin
            if (out != m_pred) begin
                e.mismatch = 1;
                m_sticky = 1;
                m_errflag = 1;
                m_errc = sat(m_errc + 1);
            end else if (rn && !sc && out == 15) begin
                m_wrapc = sat(m_wrapc + 1);
            end
            m_pred = nxt(rn, sc, out);
        end
        e.state      = r ? 0 : (m_errflag ? 2 : 1);
        e.exp_out    = m_pred;
        e.exp_valid  = m_valid;
        e.err_sticky = m_sticky;
        e.err_count  = m_errc;
        e.wrap_count = m_wrapc;
        q.push_back(e);
    endtask

    // One cycle of the modelled counter; inj replaces its output with a wrong value.
    task automatic cstep(bit r, bit rn, bit sc, bit inj);
        int o;
        o = cnt;
        if (inj) o = (m_pred + 1 + int'($urandom_range(0, 14))) % 16;
        step(r, rn, sc, o);
        cnt = nxt(rn, sc, o);
    endtask

    // Monitor: the result of each sampled edge is visible 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",      int'(state),      e.state);
                chk("exp_out",    int'(exp_out),    e.exp_out);
                chk("exp_valid",  int'(exp_valid),  e.exp_valid);
                chk("mismatch",   int'(mismatch),   e.mismatch);
                chk("err_sticky", int'(err_sticky), e.err_sticky);
                chk("err_count",  int'(err_count),  e.err_count);
                chk("wrap_count", int'(wrap_count), e.wrap_count);
                $display("cyc t=%0t rst=%0b rn=%0b sc=%0b out=%0d -> exp_out=%0d mm=%0b st=%0d errs=%0d wraps=%0d",
                         $time, rst, dut_rst_n, dut_shortcut, dut_out, exp_out, mismatch,
                         state, err_count, wrap_count);
            end
        end
    end

    initial begin
        int budget;
        cnt = 0;
        // 1: reset, counter held in reset, then clean counting
        cstep(1, 1, 0, 0);
        cstep(1, 1, 0, 0);
        cstep(0, 0, 0, 0);
        cstep(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cstep(0, 1, 0, 0);
        // 2: count up to 14, shortcut to 15, then wrap to 0
        while (cnt != 14) cstep(0, 1, 0, 0);
        cstep(0, 1, 1, 0);
        cstep(0, 1, 0, 0);
        cstep(0, 1, 0, 0);
        // 3: 3 -> 4 then a forced 9
        while (cnt != 3) cstep(0, 1, 0, 0);
        cstep(0, 1, 0, 0);
        step(0, 1, 0, 9);
        cnt = 10;
        cstep(0, 1, 0, 0);
        cstep(0, 1, 0, 0);
        // 4: reset and shortcut together at 7, counter wrongly shows 15
        while (cnt != 7) cstep(0, 1, 0, 0);
        step(0, 0, 1, 7);
        step(0, 1, 0, 15);
        cnt = 0;
        // 5: 300 consecutive faults saturate err_count
        for (int i = 0; i < 300; i++) cstep(0, 1, 0, 1);
        cstep(0, 1, 0, 0);
        // 6: monitor reset in ERROR, then resync
        cstep(1, 1, 0, 0);
        cstep(0, 1, 0, 0);
        cstep(0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            bit r, rn, sc, inj;
            r   = ($urandom_range(0, 99) < 2);
            rn  = ($urandom_range(0, 99) >= 6);
            sc  = ($urandom_range(0, 99) < 10);
            inj = ($urandom_range(0, 99) < 5);
            cstep(r, rn, sc, inj);
        end
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
